// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg
//  EXE->MEM pipeline register for the MIPS core with valid/ready flow control,
//  back-pressure hold, synchronous flush and a saturating stall counter.
//  Optional feature macro: EXE_MEM_SKID_EN adds a one-entry skid buffer and
//  turns in_ready into a registered signal (no out_ready->in_ready comb path).
//  The payload is kept as one packed vector: {WB, MEM_R, MEM_W, PC, ALU, ST, Dest}.
module exe_mem_pipe_reg #(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  WB_en_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic [PC_W-1:0]       PC_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [DATA_W-1:0]     ST_val_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WB_en,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic [PC_W-1:0]       PC,
  output logic [DATA_W-1:0]     ALU_result,
  output logic [DATA_W-1:0]     ST_val,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PAY_W = 3 + PC_W + 2 * DATA_W + REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A load+store request is illegal; the store is kept and the load dropped.
  function automatic logic [2:0] ctrl_pack(input logic wb, input logic rd, input logic wr);
    return {wb, rd & ~wr, wr};
  endfunction

  logic [PAY_W-1:0] in_pay_s;
  logic [PAY_W-1:0] load_pay_s;
  logic [PAY_W-1:0] out_pay_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             accept_s;
  logic             consume_s;
  logic             load_out_s;
  logic             clear_out_s;

  assign in_pay_s  = {ctrl_pack(WB_en_in, MEM_R_EN_in, MEM_W_EN_in),
                      PC_in, ALU_result_in, ST_val_in, Dest_in};
  assign consume_s = out_valid_r & out_ready;

`ifdef EXE_MEM_SKID_EN
  logic [PAY_W-1:0] skid_pay_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic             load_skid_s;
  logic             skid_to_out_s;

  assign in_ready = in_ready_r;
  // flush squashes the incoming instruction even when the stage could take it
  assign accept_s = in_valid & in_ready_r & ~flush;

  // Decide where this cycle's data goes: skid->out, input->out, or input->skid
  always_comb begin
    load_skid_s   = 1'b0;
    skid_to_out_s = 1'b0;
    load_out_s    = 1'b0;
    clear_out_s   = 1'b0;
    if (~out_valid_r | out_ready) begin
      if (skid_valid_r) begin
        skid_to_out_s = 1'b1;
        load_out_s    = 1'b1;
      end else if (accept_s) begin
        load_out_s    = 1'b1;
      end else begin
        clear_out_s   = 1'b1;
      end
    end else begin
      load_skid_s = accept_s;
    end
    load_pay_s = skid_to_out_s ? skid_pay_r : in_pay_s;
  end

  // Skid entry and registered in_ready; both entries are emptied by rst/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      skid_pay_r   <= '0;
    end else if (flush) begin
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (load_skid_s) begin
      skid_pay_r   <= in_pay_s;
      skid_valid_r <= 1'b1;
      in_ready_r   <= 1'b0;
    end else if (skid_to_out_s) begin
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
      in_ready_r   <= in_ready_r;
    end
  end
`else
  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready & ~flush;

  // Without a skid the output register is either loaded from EXE or drained
  always_comb begin
    load_out_s  = accept_s;
    clear_out_s = consume_s & ~accept_s;
    load_pay_s  = in_pay_s;
  end
`endif

  // Output register: payload holds when emptied, control bits are cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_pay_r   <= '0;
    end else if (flush) begin
      out_valid_r                <= 1'b0;
      out_pay_r[PAY_W-1 -: 3]    <= 3'b000;
    end else if (load_out_s) begin
      out_valid_r <= 1'b1;
      out_pay_r   <= load_pay_s;
    end else if (clear_out_s) begin
      out_valid_r                <= 1'b0;
      out_pay_r[PAY_W-1 -: 3]    <= 3'b000;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Count back-pressured cycles, saturating; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (out_valid_r & ~out_ready & (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign WB_en      = out_pay_r[PAY_W-1];
  assign MEM_R_EN   = out_pay_r[PAY_W-2];
  assign MEM_W_EN   = out_pay_r[PAY_W-3];
  assign PC         = out_pay_r[PAY_W-4 -: PC_W];
  assign ALU_result = out_pay_r[2*DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign ST_val     = out_pay_r[DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign Dest       = out_pay_r[REG_ADDR_W-1:0];
  assign stall_cnt  = stall_cnt_r;

endmodule
